config_broadcaster: RTL
=======================

CONFIG_BROADCASTER -- requirements
Module: config_broadcaster

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue entries, power of two, at least 2.
REQ-002 Parameter FLUSH_CYCLES, default 4: idle cycles between tracing deassertion and the first config byte, at least 1.
REQ-003 Parameter IDLE_ID, default 8'hFF: configId value meaning "no transfer".
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  in  1  sole clock, all state on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  host command present.
REQ-008 cmd_ready  out  1  queue can accept a command.
REQ-009 cmd_target  in  8  destination block config ID.
REQ-010 cmd_field  in  8  table select: 0 op, 1 addr_rd, 2 cond, 3 cache, 4 cache_addr.
REQ-011 cmd_chain  in  8  chain index.
REQ-012 cmd_value  in  8  table value.
REQ-013 tracing_req  in  1  host wants tracing enabled.
REQ-014 tracing  out  1  tracing enable broadcast to all pipeline blocks.
REQ-015 configId  out  8  target ID of the current byte; IDLE_ID when idle.
REQ-016 configData  out  8  config byte.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 Command accept: cmd_valid && cmd_ready on a rising edge pushes {target, field, chain, value}; cmd_ready is !full, registered.
REQ-019 Push at full is impossible because cmd_ready=0; simultaneous push and pop at full or empty keeps the count consistent.
REQ-020 FSM states: IDLE, FLUSH, FIELD, CHAIN, VALUE, NEXT.
REQ-021 IDLE -> FLUSH when the queue is non-empty; tracing goes to 0 on the same edge; the flush counter loads FLUSH_CYCLES-1.
REQ-022 FLUSH decrements each cycle and goes to FIELD at 0; configId holds IDLE_ID throughout.
REQ-023 FIELD pops the head entry, drives configId=target and configData=field, then goes to CHAIN.
REQ-024 CHAIN drives configData=chain with configId held, then goes to VALUE.
REQ-025 VALUE drives configData=value with configId held, then goes to NEXT.
REQ-026 NEXT drives configId=IDLE_ID for one cycle: if the queue is non-empty -> FIELD (no re-flush), else -> IDLE.
REQ-027 configId/configData are registered; one frame is exactly 3 consecutive non-IDLE cycles followed by at least 1 idle cycle.
REQ-028 tracing is registered: 1 only in IDLE with the queue empty and tracing_req=1; returns to 1 one cycle after re-entering IDLE.
REQ-029 Commands with target=IDLE_ID are dropped at pop, with no bytes sent and the FSM going straight to NEXT.
REQ-030 Commands pushed during the FIELD/CHAIN/VALUE states are sent in FIFO order in the same burst.
REQ-031 tracing_req changes during a burst have no effect until IDLE.

Reset
REQ-032 rst_n low at any time (including mid-frame) immediately forces: state IDLE, queue empty, tracing=0, configId=IDLE_ID, configData=0, busy=0, cmd_ready=0.
REQ-033 A partial frame is abandoned; receivers discard frames shorter than 3 bytes.
REQ-034 cmd_ready rises on the first clock edge after rst_n deasserts.

Structure
REQ-035 Shared package holds the field enum (FIELD_OP=0 .. FIELD_CACHE_ADDR=4), IDLE_ID, and the command struct type.
REQ-036 A single sub-module, config_cmd_fifo (synchronous, parameterised depth, full/empty flags), holds the queue; the FSM lives in the top module.

Verification
REQ-037 Reset then tracing_req=1, no commands -> tracing=1 two cycles after reset release; configId stays 8'hFF.
REQ-038 Push {target 3, field 1, chain 2, value 5} with tracing=1 -> tracing=0 next cycle; 4 idle cycles; then configId=3 with configData 1,2,5; then 8'hFF; tracing=1 one cycle after IDLE.
REQ-039 Push 5 commands back-to-back with depth 4 -> cmd_ready drops after the 4th push; all 5 frames are emitted in order, one gap cycle each, one flush only.
REQ-040 Push with target 8'hFF between two valid commands -> only 2 frames on configId/configData.
REQ-041 Assert rst_n=0 during the CHAIN cycle -> configId=8'hFF and tracing=0 immediately; no VALUE byte appears; the queue is empty after release.
REQ-042 Toggle tracing_req low then high during a burst -> tracing stays 0 until the burst ends, then follows tracing_req.

Source files
------------

// File: rtl/config_broadcaster_pkg.sv
// Shared types for the config broadcaster: table-select codes, the idle ID,
// the queued command record and the broadcast FSM state encoding.
package config_broadcaster_pkg;

  localparam logic [7:0] DEFAULT_IDLE_ID = 8'hFF;

  typedef enum logic [7:0] {
    FIELD_OP         = 8'd0,
    FIELD_ADDR_RD    = 8'd1,
    FIELD_COND       = 8'd2,
    FIELD_CACHE      = 8'd3,
    FIELD_CACHE_ADDR = 8'd4
  } field_e;

  typedef struct packed {
    logic [7:0] target;
    logic [7:0] field;
    logic [7:0] chain;
    logic [7:0] value;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_FIELD,
    ST_CHAIN,
    ST_VALUE,
    ST_NEXT
  } state_e;

endpackage

// File: rtl/config_cmd_fifo.sv
// Synchronous command queue with show-ahead head entry and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module config_cmd_fifo
  import config_broadcaster_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic almost_full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign count_next  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign full        = (count == (AW+1)'(DEPTH));
  assign almost_full = (count == (AW+1)'(DEPTH - 1));
  assign empty       = (count == '0);
  assign rd_data     = mem[rd_ptr];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // NOTE: storage is not reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/config_broadcaster.sv
// Queues host config commands and broadcasts each as a 3-byte frame on
// configId/configData after flushing the pipeline by dropping tracing.
module config_broadcaster
  import config_broadcaster_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter logic [7:0]  IDLE_ID      = DEFAULT_IDLE_ID
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_field,
  input  logic [7:0] cmd_chain,
  input  logic [7:0] cmd_value,
  input  logic       tracing_req,
  output logic       tracing,
  output logic [7:0] configId,
  output logic [7:0] configData,
  output logic       busy
);

  localparam int unsigned      CNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] flush_cnt;
  logic [7:0]       cur_chain;
  logic [7:0]       cur_value;
  cmd_t             wr_cmd;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             full;
  logic             almost_full;
  logic             empty;
  logic             full_next;

  assign wr_cmd = '{target: cmd_target, field: cmd_field, chain: cmd_chain, value: cmd_value};
  assign push   = cmd_valid && cmd_ready;
  // The head is consumed on the edge that would enter FIELD (end of flush or NEXT).
  assign pop    = !empty && ((state == ST_NEXT) || (state == ST_FLUSH && flush_cnt == '0));
  assign full_next = !pop && (full || (almost_full && push));

  config_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .wr_data     (wr_cmd),
    .pop         (pop),
    .rd_data     (head),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      cur_chain  <= '0;
      cur_value  <= '0;
      cmd_ready  <= 1'b0;
      tracing    <= 1'b0;
      configId   <= IDLE_ID;
      configData <= '0;
      busy       <= 1'b0;
    end else begin
      cmd_ready <= !full_next;
      tracing   <= (state == ST_IDLE) && empty && tracing_req;

      if (pop) begin
        cur_chain <= head.chain;
        cur_value <= head.value;
        busy      <= 1'b1;
        // A command addressed to the idle ID is discarded without emitting bytes.
        if (head.target == IDLE_ID) begin
          state      <= ST_NEXT;
          configId   <= IDLE_ID;
          configData <= '0;
        end else begin
          state      <= ST_FIELD;
          configId   <= head.target;
          configData <= head.field;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (!empty) begin
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_LOAD;
              busy      <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt == '0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - CNT_W'(1);
            end
          end
          ST_FIELD: begin
            state      <= ST_CHAIN;
            configData <= cur_chain;
          end
          ST_CHAIN: begin
            state      <= ST_VALUE;
            configData <= cur_value;
          end
          ST_VALUE: begin
            state      <= ST_NEXT;
            configId   <= IDLE_ID;
            configData <= '0;
          end
          ST_NEXT: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
